// File: rtl/pd_pkg.sv
// -----------------------------------------------------------------------------
// pd_pkg
// Shared definitions for the packet-decoder chunk path: header geometry,
// hash_select encodings and the chunk assembler state type.
// -----------------------------------------------------------------------------
package pd_pkg;

  // 640-bit block header = 20 x 32-bit words; the first 16 form chunk_1.
  localparam int PD_HDR_WORDS    = 20;
  localparam int PD_CHUNK1_WORDS = 16;

  // hash_select encodings seen by the chunk decoder / SHA-256 core.
  localparam logic [1:0] HASH_SEL_CHUNK1 = 2'd0;
  localparam logic [1:0] HASH_SEL_CHUNK2 = 2'd1;

  // Assembler sequencing states.
  typedef enum logic [2:0] {
    LOAD1,       // collecting words 0-15
    HASH1,       // chunk_1 hashing, words 16-19 still loading
    HASH1_FULL,  // all 20 words held, chunk_1 hash still running
    WAIT2,       // chunk_1 hashed, waiting for the rest of words 16-19
    HASH2        // padded chunk_2 hashing
  } pd_asm_state_t;

endpackage

// File: rtl/pd_chunk_assembler.sv
// -----------------------------------------------------------------------------
// pd_chunk_assembler
// Writer side of the packet-decoder chunk path. Collects a 20-word big-endian
// block header from a valid/ready stream, packs words 0-15 into chunk_1 and
// words 16-19 into chunk_2, and sequences chunk_valid / hash_select so the
// hasher consumes chunk_1 first (overlapping the load of words 16-19) and then
// the padded chunk_2.
//
// Ports
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   in_valid     in_word carries a header word this cycle
//   in_word      next header word, MSB-first
//   in_ready     block accepts a word this cycle (combinational from state)
//   new_block    synchronous abort/restart, beats every other event
//   hash_done    hasher consumed the presented chunk (1-cycle pulse)
//   chunk_1      header words 0-15, word 0 in [511:480]
//   chunk_2      header words 16-19, word 16 in [127:96]
//   hash_select  0 = chunk_1, 1 = padded chunk_2
//   chunk_valid  chunk data and hash_select are stable and ready to hash
//   block_done   registered pulse the cycle after the chunk_2 hash_done
// -----------------------------------------------------------------------------
module pd_chunk_assembler
  import pd_pkg::*;
#(
  parameter int HDR_WORDS    = PD_HDR_WORDS,
  parameter int CHUNK1_WORDS = PD_CHUNK1_WORDS
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        in_valid,
  input  logic [31:0]                 in_word,
  output logic                        in_ready,
  input  logic                        new_block,
  input  logic                        hash_done,
  output logic [32*CHUNK1_WORDS-1:0]  chunk_1,
  output logic [32*(HDR_WORDS-CHUNK1_WORDS)-1:0] chunk_2,
  output logic [1:0]                  hash_select,
  output logic                        chunk_valid,
  output logic                        block_done
);

  localparam int CHUNK2_WORDS = HDR_WORDS - CHUNK1_WORDS;
  localparam int C1_BITS      = 32 * CHUNK1_WORDS;
  localparam int C2_BITS      = 32 * CHUNK2_WORDS;

  pd_asm_state_t       state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [C1_BITS-1:0]  chunk1_q, chunk1_d;
  logic [C2_BITS-1:0]  chunk2_q, chunk2_d;
  logic                block_done_q, block_done_d;

  logic accept;
  logic last_of_chunk1;
  logic last_of_header;

  // ---------------------------------------------------------------------------
  // Handshake outputs are a pure function of state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    in_ready    = 1'b0;
    chunk_valid = 1'b0;
    hash_select = HASH_SEL_CHUNK1;
    unique case (state_q)
      LOAD1:      begin in_ready = 1'b1; end
      HASH1:      begin in_ready = 1'b1; chunk_valid = 1'b1; end
      HASH1_FULL: begin chunk_valid = 1'b1; end
      WAIT2:      begin in_ready = 1'b1; hash_select = HASH_SEL_CHUNK2; end
      HASH2:      begin chunk_valid = 1'b1; hash_select = HASH_SEL_CHUNK2; end
      default:    begin end
    endcase
  end

  // A beat offered alongside new_block is dropped even though in_ready may
  // read high.
  assign accept         = in_valid && in_ready && !new_block;
  assign last_of_chunk1 = (cnt_q == 5'(CHUNK1_WORDS - 1));
  assign last_of_header = (cnt_q == 5'(HDR_WORDS - 1));

  // ---------------------------------------------------------------------------
  // Next-state, counter and packing logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    chunk1_d     = chunk1_q;
    chunk2_d     = chunk2_q;
    block_done_d = 1'b0;

    // Word storage. in_ready is low in HASH1_FULL and HASH2, and the counter
    // is already past 15 in HASH1, so chunk_1 cannot change while it is being
    // hashed and neither chunk can change during the chunk_2 hash.
    if (accept) begin
      cnt_d = cnt_q + 5'd1;
      for (int i = 0; i < CHUNK1_WORDS; i++) begin
        if (cnt_q == 5'(i)) chunk1_d[32*(CHUNK1_WORDS-i)-1 -: 32] = in_word;
      end
      for (int j = 0; j < CHUNK2_WORDS; j++) begin
        if (cnt_q == 5'(CHUNK1_WORDS + j)) chunk2_d[32*(CHUNK2_WORDS-j)-1 -: 32] = in_word;
      end
    end

    // hash_done only matters in states presenting a chunk (chunk_valid=1).
    unique case (state_q)
      LOAD1: begin
        if (accept && last_of_chunk1) state_d = HASH1;
      end
      HASH1: begin
        if (accept && last_of_header && hash_done) state_d = HASH2;
        else if (hash_done)                        state_d = WAIT2;
        else if (accept && last_of_header)         state_d = HASH1_FULL;
      end
      HASH1_FULL: begin
        if (hash_done) state_d = HASH2;
      end
      WAIT2: begin
        if (accept && last_of_header) state_d = HASH2;
      end
      HASH2: begin
        if (hash_done) begin
          state_d      = LOAD1;
          cnt_d        = 5'd0;
          block_done_d = 1'b1;
        end
      end
      default: state_d = LOAD1;
    endcase

    // Abort/restart overrides everything computed above.
    if (new_block) begin
      state_d      = LOAD1;
      cnt_d        = 5'd0;
      chunk1_d     = '0;
      chunk2_d     = '0;
      block_done_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: the chunk registers are plain flops (not a RAM), so they are
      // cleared by reset like the rest of the state; downstream sees zeros.
      state_q      <= LOAD1;
      cnt_q        <= 5'd0;
      chunk1_q     <= '0;
      chunk2_q     <= '0;
      block_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge value of every other register.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      chunk1_q     <= chunk1_d;
      chunk2_q     <= chunk2_d;
      block_done_q <= block_done_d;
    end
  end

  assign chunk_1    = chunk1_q;
  assign chunk_2    = chunk2_q;
  assign block_done = block_done_q;

endmodule

// File: tb/tb_pd_chunk_assembler.sv
// -----------------------------------------------------------------------------
// tb_pd_chunk_assembler
// Self-checking bench for pd_chunk_assembler. A behavioural model tracks the
// header as an array of words plus "how many words loaded" and "chunk_1 hashed
// yet", and derives every output from those; a compare process checks the DUT
// against it on every falling edge. Directed scenarios add literal checks,
// followed by a randomized run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pd_chunk_assembler;

  logic          clk;
  logic          n_rst;
  logic          in_valid;
  logic [31:0]   in_word;
  logic          in_ready;
  logic          new_block;
  logic          hash_done;
  logic [511:0]  chunk_1;
  logic [127:0]  chunk_2;
  logic [1:0]    hash_select;
  logic          chunk_valid;
  logic          block_done;

  int checks = 0;
  int passes = 0;
  int blk_cnt = 0;

  pd_chunk_assembler dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .new_block  (new_block),
    .hash_done  (hash_done),
    .chunk_1    (chunk_1),
    .chunk_2    (chunk_2),
    .hash_select(hash_select),
    .chunk_valid(chunk_valid),
    .block_done (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: words loaded so far, whether chunk_1 has been hashed.
  // ---------------------------------------------------------------------------
  int          m_cnt;
  bit          m_c1_hashed;
  logic [31:0] m_w [20];
  logic        m_bd;

  function automatic logic m_ready();
    return m_cnt < 20;
  endfunction
  function automatic logic m_cv();
    return (m_cnt >= 16 && !m_c1_hashed) || (m_cnt == 20 && m_c1_hashed);
  endfunction
  function automatic logic [1:0] m_sel();
    return m_c1_hashed ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [511:0] m_chunk1();
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[479:0], m_w[i]};
    return v;
  endfunction
  function automatic logic [127:0] m_chunk2();
    logic [127:0] v = '0;
    for (int i = 16; i < 20; i++) v = {v[95:0], m_w[i]};
    return v;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_cnt = 0; m_c1_hashed = 0; m_bd = 0;
      for (int i = 0; i < 20; i++) m_w[i] = '0;
    end else if (new_block) begin
      m_cnt = 0; m_c1_hashed = 0; m_bd = 0;
      for (int i = 0; i < 20; i++) m_w[i] = '0;
    end else begin
      bit finished;
      bit acc;
      finished = 0;
      acc      = in_valid && m_ready();
      if (hash_done && m_cv()) begin
        if (!m_c1_hashed) m_c1_hashed = 1;
        else finished = 1;
      end
      if (acc) begin
        m_w[m_cnt] = in_word;
        m_cnt++;
      end
      m_bd = finished;
      if (finished) begin
        m_cnt = 0; m_c1_hashed = 0;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("in_ready",    512'(in_ready),    512'(m_ready()));
    check("chunk_valid", 512'(chunk_valid), 512'(m_cv()));
    check("hash_select", 512'(hash_select), 512'(m_sel()));
    check("block_done",  512'(block_done),  512'(m_bd));
    check("chunk_1",     chunk_1,           m_chunk1());
    check("chunk_2",     512'(chunk_2),     512'(m_chunk2()));
    if (block_done) blk_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1ns after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int guard;
      in_valid = 1'b1;
      in_word  = base + 32'(i);
      acc = 0;
      guard = 0;
      while (!acc && guard < 200) begin
        acc = in_ready && !new_block;
        cycle();
        guard++;
      end
      if (!acc) check("word_accept_timeout", 512'(0), 512'(1));
    end
    in_valid = 1'b0;
  endtask

  task automatic hasher(input int delay, input logic [1:0] sel);
    int guard = 0;
    while (!(chunk_valid && hash_select == sel) && guard < 200) begin
      cycle();
      guard++;
    end
    if (guard >= 200) check("chunk_valid_timeout", 512'(0), 512'(1));
    repeat (delay) cycle();
    hash_done = 1'b1;
    cycle();
    hash_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] saved;
    logic [511:0] exp1;
    logic [127:0] exp2;
    int           bd_before;

    n_rst = 1'b0; in_valid = 1'b0; in_word = '0; new_block = 1'b0; hash_done = 1'b0;
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b1;
    cycle();

    // Reset state.
    check("rst_in_ready",    512'(in_ready),    512'(1));
    check("rst_chunk_valid", 512'(chunk_valid), 512'(0));
    check("rst_hash_select", 512'(hash_select), 512'(0));
    check("rst_chunk_1",     chunk_1,           512'(0));
    check("rst_block_done",  512'(block_done),  512'(0));

    // 1: 20 words 1..20, hash_done 3 cycles after chunk_valid.
    bd_before = blk_cnt;
    fork
      drive_words(20, 32'h1);
      begin
        hasher(3, 2'd0);
        hasher(3, 2'd1);
      end
    join
    cycle();
    check("t1_chunk_1", chunk_1,
          {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8,
           32'h9, 32'ha, 32'hb, 32'hc, 32'hd, 32'he, 32'hf, 32'h10});
    check("t1_chunk_2", 512'(chunk_2), 512'({32'h11, 32'h12, 32'h13, 32'h14}));
    check("t1_block_done_count", 512'(blk_cnt - bd_before), 512'(1));

    // 2: chunk_1 hashed before word 17 arrives -> WAIT2.
    drive_words(16, 32'h100);
    check("t2_cv_after_16", 512'(chunk_valid), 512'(1));
    check("t2_sel_after_16", 512'(hash_select), 512'(0));
    hasher(0, 2'd0);
    check("t2_wait2_cv",    512'(chunk_valid), 512'(0));
    check("t2_wait2_sel",   512'(hash_select), 512'(1));
    check("t2_wait2_ready", 512'(in_ready),    512'(1));
    drive_words(4, 32'h110);
    check("t2_cv_after_20", 512'(chunk_valid), 512'(1));
    check("t2_sel_after_20", 512'(hash_select), 512'(1));
    hasher(1, 2'd1);
    cycle();

    // 3: all 20 words, no hash_done -> HASH1_FULL holds off new words.
    drive_words(20, 32'h200);
    saved = chunk_1;
    in_valid = 1'b1;
    in_word  = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      check("t3_full_ready", 512'(in_ready), 512'(0));
      cycle();
    end
    check("t3_chunk_1_stable", chunk_1, saved);
    check("t3_chunk_2", 512'(chunk_2), 512'({32'h210, 32'h211, 32'h212, 32'h213}));
    in_valid = 1'b0;
    hasher(0, 2'd0);
    hasher(0, 2'd1);
    cycle();

    // 4: word 20 accept coincides with chunk_1 hash_done -> straight to HASH2.
    drive_words(19, 32'h300);
    in_valid = 1'b1; in_word = 32'h313; hash_done = 1'b1;
    cycle();
    in_valid = 1'b0; hash_done = 1'b0;
    check("t4_hash2_ready", 512'(in_ready),    512'(0));
    check("t4_hash2_cv",    512'(chunk_valid), 512'(1));
    check("t4_hash2_sel",   512'(hash_select), 512'(1));
    hasher(0, 2'd1);
    cycle();

    // 5: new_block after 18 words with a concurrent beat.
    drive_words(18, 32'h400);
    new_block = 1'b1; in_valid = 1'b1; in_word = 32'h0BAD0BAD;
    cycle();
    new_block = 1'b0; in_valid = 1'b0;
    check("t5_chunk_1", chunk_1,          512'(0));
    check("t5_chunk_2", 512'(chunk_2),    512'(0));
    check("t5_cv",      512'(chunk_valid), 512'(0));
    check("t5_ready",   512'(in_ready),    512'(1));
    fork
      drive_words(20, 32'h500);
      begin
        hasher(2, 2'd0);
        hasher(2, 2'd1);
      end
    join
    exp1 = '0;
    for (int i = 0; i < 16; i++) exp1 = {exp1[479:0], 32'h500 + 32'(i)};
    exp2 = '0;
    for (int i = 16; i < 20; i++) exp2 = {exp2[95:0], 32'h500 + 32'(i)};
    check("t5_reassembled_1", chunk_1, exp1);
    check("t5_reassembled_2", 512'(chunk_2), 512'(exp2));
    cycle();

    // 6: asynchronous reset mid-HASH2.
    drive_words(20, 32'h600);
    hasher(0, 2'd0);
    check("t6_in_hash2", 512'(hash_select), 512'(1));
    #2 n_rst = 1'b0;
    #1;
    check("t6_async_chunk_1", chunk_1,           512'(0));
    check("t6_async_chunk_2", 512'(chunk_2),     512'(0));
    check("t6_async_ready",   512'(in_ready),    512'(1));
    check("t6_async_cv",      512'(chunk_valid), 512'(0));
    check("t6_async_sel",     512'(hash_select), 512'(0));
    check("t6_async_bd",      512'(block_done),  512'(0));
    cycle();
    #3 n_rst = 1'b1;
    cycle();
    bd_before = blk_cnt;
    hash_done = 1'b1;
    cycle();
    hash_done = 1'b0;
    repeat (3) cycle();
    check("t6_no_block_done", 512'(blk_cnt - bd_before), 512'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_word   = $urandom;
      hash_done = ($urandom_range(0, 9) < 3);
      new_block = ($urandom_range(0, 199) < 2);
      cycle();
    end
    in_valid = 1'b0; hash_done = 1'b0; new_block = 1'b0;
    repeat (2) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pd_chunk_assembler.md
Name: pd_chunk_assembler

Overview:
Writer side of the packet-decoder chunk path. It accepts the 640-bit block header as 20 big-endian 32-bit words over a valid/ready stream. It packs words 0-15 into chunk_1 and words 16-19 into chunk_2. It then sequences hash_select and chunk_valid so the chunk decoder and SHA-256 core consume chunk_1 first, then the padded chunk_2. The chunk_1 hash overlaps with loading of words 16-19.

Parameters:
HDR_WORDS, 20, header length in 32-bit words (fixed for 640-bit header).
CHUNK1_WORDS, 16, words packed into chunk_1 (512 bits).

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
in_valid  input  1  in_word is valid this cycle.
in_word  input  32  next header word, MSB-first order.
in_ready  output  1  block can accept a word this cycle.
new_block  input  1  synchronous abort/restart; discards the partial header.
hash_done  input  1  hasher has consumed the presented chunk; 1-cycle pulse.
chunk_1  output  512  header words 0-15; word 0 in [511:480].
chunk_2  output  128  header words 16-19; word 16 in [127:96].
hash_select  output  2  0 = hash chunk_1; 1 = hash padded chunk_2; 2 and 3 are never driven.
chunk_valid  output  1  hash_select and chunk data are stable and ready to hash.
block_done  output  1  1-cycle registered pulse after chunk_2 hash_done.

Behaviour:
- Reset (n_rst=0, async) drives the following:
  - state=LOAD1, word counter=0.
  - chunk_1=0, chunk_2=0, block_done=0.
  - Outputs after reset release: in_ready=1, chunk_valid=0, hash_select=0.
- Word accept occurs when in_valid && in_ready. Storage rules:
  - Word at index k<16 is stored to chunk_1[511-32k -: 32].
  - Word at index 16+j is stored to chunk_2[127-32j -: 32].
  - The counter increments on every accept.
- in_ready, chunk_valid and hash_select are combinational from state.
- States, with (in_ready, chunk_valid, hash_select):
  - LOAD1 (1, 0, 0): on accept of index 15 -> HASH1.
  - HASH1 (1, 1, 0): transitions depend on the same-cycle events:
    - accept of index 19 and hash_done -> HASH2.
    - hash_done only -> WAIT2.
    - accept of index 19 only -> HASH1_FULL.
  - HASH1_FULL (0, 1, 0): hash_done -> HASH2.
  - WAIT2 (1, 0, 1): accept of index 19 -> HASH2.
  - HASH2 (0, 1, 1): hash_done -> LOAD1, counter=0, block_done=1 on the next cycle.
- Stability guarantees:
  - chunk_1 is never written while chunk_valid=1 with hash_select=0.
  - chunk_2 and chunk_1 are never written in HASH2.
- hash_done is ignored whenever chunk_valid=0 (LOAD1, WAIT2).
- new_block priority: it has priority over all other events in the same cycle.
  - Next state is LOAD1, counter=0, chunk_1=0, chunk_2=0, block_done=0.
  - A word offered in that cycle is not accepted; in_ready still reads per the current state, but the beat is dropped.
  - A concurrent hash_done is ignored.
- Latency:
  - chunk_valid rises the cycle after the 16th word is accepted.
  - HASH2 is entered the cycle after the later of hash_done(chunk_1) and the 20th accept.
  - block_done follows hash_done(chunk_2) by 1 cycle.
- Counter width is 5 bits and it never exceeds 20; the counter wraps to 0 only via HASH2 exit or new_block.
- Back-to-back blocks: LOAD1 accepts word 0 of the next header in the cycle block_done is high.

Decomposition:
- Shared package pd_pkg holds:
  - PD_HDR_WORDS=20, PD_CHUNK1_WORDS=16.
  - HASH_SEL_CHUNK1=2'd0, HASH_SEL_CHUNK2=2'd1.
  - typedef enum pd_asm_state_t {LOAD1, HASH1, HASH1_FULL, WAIT2, HASH2}.
- Single module; no sub-module is warranted, and the counter and packing registers stay inline.

Test Plan:
1. Reset, then 20 back-to-back words 0x00000001..0x00000014, hash_done pulsed 3 cycles after chunk_valid.
   - Required: chunk_1={0x1..0x10}, chunk_2={0x11,0x12,0x13,0x14}.
   - Required: chunk_valid=1 the cycle after word 0x10 is accepted, hash_select 0 then 1.
   - Required: block_done one cycle after the second hash_done.
2. hash_done for chunk_1 arrives before word 17 is accepted.
   - Required: WAIT2 is entered, chunk_valid=0, hash_select=1, in_ready=1.
   - Required: chunk_valid=1 the cycle after word 20 is accepted.
3. All 20 words arrive with no hash_done.
   - Required: HASH1_FULL, in_ready=0, and chunk_1 stays unchanged while in_valid is held high with in_word=0xDEADBEEF.
4. Word 20 accept and hash_done coincide in HASH1.
   - Required: HASH2 next cycle, with no WAIT2 and no HASH1_FULL visited.
5. new_block asserted after 18 words, together with in_valid.
   - Required: counter=0, chunk_1=chunk_2=0, chunk_valid=0, and that beat dropped.
   - Required: the next 20 words assemble correctly.
6. n_rst asserted mid-HASH2.
   - Required: outputs go to reset values immediately (async).
   - Required: a hash_done after release is ignored and no block_done occurs.
